// File: rtl/regfile_multiport.sv
// ---------------------------------------------------------------------------
// regfile_multiport
//
// Multi-ported register file with a per-register pending ("reserved") bit,
// intended for a scoreboarded pipeline: an issuing instruction reserves its
// destination register, and the writeback that later produces the value
// clears the reservation.
//
// Behaviour summary
//   - Register 0 is hard-wired: it reads as zero, is never pending, and
//     silently ignores writes and reserves.
//   - Writes land on the rising edge when en=1. When several write ports hit
//     the same register, the highest-numbered port wins.
//   - Reads are registered (one-cycle latency) and forward same-cycle write
//     data using the same priority as the array update.
//   - rd_busy reports the pending bit after this cycle's write-clear and
//     before this cycle's reserve-set. A forwarded value is therefore never
//     flagged busy, and a register reserved in this cycle shows busy only
//     from the next read onward.
//   - en=0 freezes the array, the pending bits and both output registers.
//
// Ports
//   clk       in   1               rising-edge clock
//   rst_n     in   1               asynchronous active-low reset
//   en        in   1               global enable (low = stall, hold all)
//   wr_en     in   NUM_WR          per-port write strobe
//   wr_addr   in   NUM_WR*ADDR_W   write addresses, port k at [k*ADDR_W +: ADDR_W]
//   wr_data   in   NUM_WR*DATA_W   write data, port k at [k*DATA_W +: DATA_W]
//   rsv_en    in   1               reserve strobe (mark rsv_addr pending)
//   rsv_addr  in   ADDR_W          register to reserve
//   rd_addr   in   NUM_RD*ADDR_W   read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data   out  NUM_RD*DATA_W   registered read data
//   rd_busy   out  NUM_RD          registered pending flag per read port
//
// Parameters
//   DATA_W  register width (default 32)
//   ADDR_W  address width, SIZE = 2**ADDR_W registers (default 5)
//   NUM_RD  read ports, 1..4 (default 2)
//   NUM_WR  write ports, 1..2 (default 2)
// ---------------------------------------------------------------------------
module regfile_multiport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int SIZE = 2 ** ADDR_W;

  // Architectural state
  logic [DATA_W-1:0]        r_mem [SIZE];
  logic [SIZE-1:0]          r_pend;
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD-1:0]        r_rd_busy;

  // Per-register resolved write: hit flag and the value the register will
  // hold after this edge (its current value when not written). Reusing this
  // array for the read path gives forwarding with exactly the same
  // port priority as the array update.
  logic [SIZE-1:0]          w_wr_hit;
  logic [DATA_W-1:0]        w_wr_val [SIZE];
  logic [SIZE-1:0]          w_pend_nxt;

  // Read-path next values
  logic [ADDR_W-1:0]        w_rd_idx [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]        w_rd_busy;

  // Resolve all write ports per register; later ports override earlier ones.
  always_comb begin
    for (int j = 0; j < SIZE; j++) begin
      w_wr_hit[j] = 1'b0;
      w_wr_val[j] = r_mem[j];
      for (int k = 0; k < NUM_WR; k++) begin
        if ((j != 0) && wr_en[k] &&
            (wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(j))) begin
          w_wr_hit[j] = 1'b1;
          w_wr_val[j] = wr_data[k*DATA_W +: DATA_W];
        end else begin
          w_wr_hit[j] = w_wr_hit[j];
          w_wr_val[j] = w_wr_val[j];
        end
      end
    end
  end

  // Pending-bit update: a write clears, a reserve sets, and the reserve is
  // applied last so it wins a same-cycle collision. Register 0 stays clear.
  always_comb begin
    for (int j = 0; j < SIZE; j++) begin
      if (j == 0) begin
        w_pend_nxt[j] = 1'b0;
      end else begin
        w_pend_nxt[j] = (r_pend[j] & ~w_wr_hit[j]) |
                        (rsv_en && (rsv_addr == ADDR_W'(j)));
      end
    end
  end

  // Read ports: forwarded data and busy sampled between clear and set.
  always_comb begin
    w_rd_data = {(NUM_RD*DATA_W){1'b0}};
    w_rd_busy = {NUM_RD{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_idx[i] = rd_addr[i*ADDR_W +: ADDR_W];
      if (w_rd_idx[i] == {ADDR_W{1'b0}}) begin
        w_rd_data[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        w_rd_busy[i]                  = 1'b0;
      end else begin
        w_rd_data[i*DATA_W +: DATA_W] = w_wr_val[w_rd_idx[i]];
        // Busy is reported before this cycle's reserve, so use the
        // post-clear value rather than w_pend_nxt.
        w_rd_busy[i]                  = r_pend[w_rd_idx[i]] & ~w_wr_hit[w_rd_idx[i]];
      end
    end
  end

  // State and output registers; asynchronous reset discards any same-cycle
  // write or reserve, and en=0 holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < SIZE; j++) begin
        r_mem[j] <= {DATA_W{1'b0}};
      end
      r_pend    <= {SIZE{1'b0}};
      r_rd_data <= {(NUM_RD*DATA_W){1'b0}};
      r_rd_busy <= {NUM_RD{1'b0}};
    end else if (en) begin
      for (int j = 0; j < SIZE; j++) begin
        r_mem[j] <= w_wr_val[j];
      end
      r_pend    <= w_pend_nxt;
      r_rd_data <= w_rd_data;
      r_rd_busy <= w_rd_busy;
    end else begin
      for (int j = 0; j < SIZE; j++) begin
        r_mem[j] <= r_mem[j];
      end
      r_pend    <= r_pend;
      r_rd_data <= r_rd_data;
      r_rd_busy <= r_rd_busy;
    end
  end

  assign rd_data = r_rd_data;
  assign rd_busy = r_rd_busy;

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;

  logic                     clk;
  logic                     rst_n;
  logic                     en;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  int n_checks;
  int n_errors;

  regfile_multiport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and move 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [1:0] en_v,
                        input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
    wr_en   = en_v;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic set_rsv(input logic v, input logic [4:0] a);
    rsv_en   = v;
    rsv_addr = a;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_rsv(1'b0, 5'd0);
    set_rd(5'd0, 5'd0);

    // Reset state
    #12;
    check("reset_rd0", rd_data[31:0], 32'h0);
    check("reset_rd1", rd_data[63:32], 32'h0);
    check("reset_busy", {30'b0, rd_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Port0 writes r3, port1 reads next cycle
    set_wr(2'b01, 5'd3, 32'h1234, 5'd0, 32'h0);
    tick();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_rd(5'd0, 5'd3);
    tick();
    check("r3_rd1", rd_data[63:32], 32'h1234);
    check("r3_busy1", {31'b0, rd_busy[1]}, 32'h0);

    // Both ports write r5, port1 wins, forwarded same cycle
    set_wr(2'b11, 5'd5, 32'hAAAA, 5'd5, 32'h5555);
    set_rd(5'd5, 5'd0);
    tick();
    check("r5_fwd_rd0", rd_data[31:0], 32'h5555);
    check("r5_fwd_busy0", {31'b0, rd_busy[0]}, 32'h0);
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_rd(5'd5, 5'd5);
    tick();
    check("r5_later_rd0", rd_data[31:0], 32'h5555);
    check("r5_later_rd1", rd_data[63:32], 32'h5555);

    // Reserve r7, read busy, then port1 write with same-cycle read
    set_rsv(1'b1, 5'd7);
    tick();
    set_rsv(1'b0, 5'd0);
    set_rd(5'd7, 5'd0);
    tick();
    check("r7_busy0", {31'b0, rd_busy[0]}, 32'h1);
    set_wr(2'b10, 5'd0, 32'h0, 5'd7, 32'h77);
    tick();
    check("r7_fwd_rd0", rd_data[31:0], 32'h77);
    check("r7_fwd_busy0", {31'b0, rd_busy[0]}, 32'h0);
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    check("r7_cleared_busy0", {31'b0, rd_busy[0]}, 32'h0);
    check("r7_stored_rd0", rd_data[31:0], 32'h77);

    // Reserve and write r9 together: data written, reserve wins
    set_rsv(1'b1, 5'd9);
    set_wr(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
    set_rd(5'd9, 5'd0);
    tick();
    check("r9_same_rd0", rd_data[31:0], 32'h99);
    check("r9_same_busy0", {31'b0, rd_busy[0]}, 32'h0);
    set_rsv(1'b0, 5'd0);
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    check("r9_rd0", rd_data[31:0], 32'h99);
    check("r9_busy0", {31'b0, rd_busy[0]}, 32'h1);

    // Register 0: write and reserve are ignored
    set_wr(2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0);
    set_rsv(1'b1, 5'd0);
    set_rd(5'd0, 5'd0);
    tick();
    check("r0_fwd_rd0", rd_data[31:0], 32'h0);
    check("r0_fwd_rd1", rd_data[63:32], 32'h0);
    check("r0_fwd_busy", {30'b0, rd_busy}, 32'h0);
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_rsv(1'b0, 5'd0);
    tick();
    check("r0_rd0", rd_data[31:0], 32'h0);
    check("r0_busy", {30'b0, rd_busy}, 32'h0);

    // Stall: load known outputs, then en=0 with write/reserve/read changes
    set_rd(5'd3, 5'd9);
    tick();
    check("pre_stall_rd0", rd_data[31:0], 32'h1234);
    check("pre_stall_rd1", rd_data[63:32], 32'h99);
    check("pre_stall_busy", {30'b0, rd_busy}, 32'h2);
    en = 1'b0;
    set_wr(2'b01, 5'd4, 32'h44, 5'd0, 32'h0);
    set_rsv(1'b1, 5'd4);
    set_rd(5'd4, 5'd4);
    tick();
    tick();
    check("stall_rd0", rd_data[31:0], 32'h1234);
    check("stall_rd1", rd_data[63:32], 32'h99);
    check("stall_busy", {30'b0, rd_busy}, 32'h2);
    en = 1'b1;
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_rsv(1'b0, 5'd0);
    tick();
    check("r4_rd0", rd_data[31:0], 32'h0);
    check("r4_rd1", rd_data[63:32], 32'h0);
    check("r4_busy", {30'b0, rd_busy}, 32'h0);

    // Asynchronous reset mid-operation
    set_wr(2'b01, 5'd1, 32'h11, 5'd0, 32'h0);
    tick();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_rsv(1'b1, 5'd2);
    set_rd(5'd1, 5'd0);
    tick();
    set_rsv(1'b0, 5'd0);
    set_rd(5'd1, 5'd2);
    tick();
    check("pre_rst_rd0", rd_data[31:0], 32'h11);
    check("pre_rst_busy1", {31'b0, rd_busy[1]}, 32'h1);
    set_wr(2'b01, 5'd1, 32'h22, 5'd0, 32'h0);
    set_rsv(1'b1, 5'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_now_rd0", rd_data[31:0], 32'h0);
    check("rst_now_rd1", rd_data[63:32], 32'h0);
    check("rst_now_busy", {30'b0, rd_busy}, 32'h0);
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_rsv(1'b0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset works normally
    set_wr(2'b01, 5'd6, 32'h66, 5'd0, 32'h0);
    set_rd(5'd1, 5'd2);
    tick();
    check("post_rst_r1", rd_data[31:0], 32'h0);
    check("post_rst_r2_busy", {31'b0, rd_busy[1]}, 32'h0);
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_rd(5'd6, 5'd6);
    tick();
    check("post_rst_r6_rd0", rd_data[31:0], 32'h66);
    check("post_rst_r6_rd1", rd_data[63:32], 32'h66);
    check("post_rst_r6_busy", {30'b0, rd_busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
